// File: rtl/misr_pkg.sv
// misr_pkg: shared types, constants and the MISR update function for the
// signature-analysis stage of the ripple-adder BIST path.
//   state_e    : checker FSM states (IDLE / RUN / CHECK)
//   MISR_W     : signature width, equal to the compactor output width
//   CNT_W      : pattern counter width
//   DEF_POLY   : default feedback taps, x^6+x+1
//   DEF_SEED   : default signature value at reset and at session start
//   misr_next  : one MISR step folding a data word into the signature
package misr_pkg;

    localparam int MISR_W = 6;
    localparam int CNT_W  = 16;

    localparam logic [MISR_W-1:0] DEF_POLY = 6'h03;
    localparam logic [MISR_W-1:0] DEF_SEED = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Shift left by one; if the bit shifted out was set, XOR in the taps.
    // The incoming word is XORed over the whole register in parallel.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] d,
        input logic [MISR_W-1:0] poly
    );
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? poly : '0;
        return {sig[MISR_W-2:0], 1'b0} ^ fb ^ d;
    endfunction

endpackage

// File: rtl/misr_if.sv
// misr_if: bus between the compactor / BIST controller (master) and the
// signature checker (slave).
//   start, golden        : session request and expected final signature
//   com_valid, com_res   : compacted word stream from the compactor
//   busy, done, pass     : session status
//   signature, pat_cnt   : current MISR contents and accepted-word count
//
// Handshake: there is no ready. A word is consumed on every rising edge at
// which com_valid is high and the checker is in RUN; words presented in any
// other state are dropped. start is likewise only consumed in IDLE.
interface misr_if
    import misr_pkg::*;
#(
    parameter int W = MISR_W
);
    logic             start;
    logic [W-1:0]     golden;
    logic             com_valid;
    logic [W-1:0]     com_res;
    logic             busy;
    logic             done;
    logic             pass;
    logic [W-1:0]     signature;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output start, golden, com_valid, com_res,
        input  busy, done, pass, signature, pat_cnt
    );

    modport slave (
        input  start, golden, com_valid, com_res,
        output busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/misr_reg.sv
// misr_reg: W-bit multiple-input signature register.
//   clk, rst_i  : clock and synchronous active-high reset (loads SEED)
//   load_i      : reload SEED (session start); wins over en_i
//   en_i        : fold d_i into the signature this edge
//   d_i         : parallel data word
//   sig_o       : registered signature
module misr_reg
    import misr_pkg::*;
#(
    parameter int          W    = MISR_W,
    parameter logic [W-1:0] POLY = DEF_POLY,
    parameter logic [W-1:0] SEED = DEF_SEED
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = misr_next(sig_q, d_i, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/misr_checker.sv
// misr_checker: folds NPAT compacted words into a MISR, then compares the
// final signature with the golden value latched at session start.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : misr_if slave (start/golden/com_valid/com_res in,
//               busy/done/pass/signature/pat_cnt out)
//   state_o   : current FSM state, for observation only
// All outputs come straight from registers.
module misr_checker
    import misr_pkg::*;
#(
    parameter int           W    = MISR_W,
    parameter int           NPAT = 16,
    parameter logic [W-1:0] POLY = DEF_POLY,
    parameter logic [W-1:0] SEED = DEF_SEED
) (
    input  logic   clk,
    input  logic   rst,
    misr_if.slave  bus,
    output state_e state_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPAT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     golden_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [W-1:0]     sig_w;

    logic             load_w;
    logic             accept_w;

    // Seed on the accepted start; fold only words arriving while in RUN.
    assign load_w   = (state_q == ST_IDLE) && bus.start;
    assign accept_w = (state_q == ST_RUN) && bus.com_valid;

    misr_reg #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr_reg (
        .clk    (clk),
        .rst_i  (rst),
        .load_i (load_w),
        .en_i   (accept_w),
        .d_i    (bus.com_res),
        .sig_o  (sig_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            golden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt_q    <= '0;
                        golden_q <= bus.golden;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.com_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        // Last word of the session: the counter never needs
                        // to go past NPAT, so no saturation is required.
                        if (cnt_q == LAST_IDX) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // The last fold landed at the previous edge, so sig_w
                    // already holds the final signature here.
                    pass_q  <= (sig_w == golden_q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_w;
    assign bus.pat_cnt   = cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_misr_checker.sv
// Bench for misr_checker: three instances with NPAT = 1, 2 and 16 share one
// clock and reset; directed scenarios with hand-computed signatures.
module tb_misr_checker;
    import misr_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    state_e st_a;
    state_e st_b;
    state_e st_c;

    misr_if #(.W(6)) if_a ();
    misr_if #(.W(6)) if_b ();
    misr_if #(.W(6)) if_c ();

    misr_checker #(.W(6), .NPAT(1),  .POLY(6'h03), .SEED(6'h3F)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .state_o(st_a));
    misr_checker #(.W(6), .NPAT(2),  .POLY(6'h03), .SEED(6'h3F)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .state_o(st_b));
    misr_checker #(.W(6), .NPAT(16), .POLY(6'h03), .SEED(6'h3F)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c), .state_o(st_c));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference MISR step: shift, feedback taps x^6+x+1, fold word in.
    function automatic logic [5:0] model_next(input logic [5:0] s, input logic [5:0] d);
        logic [5:0] r;
        r = {s[4:0], 1'b0};
        if (s[5]) r = r ^ 6'h03;
        return r ^ d;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (if_a.signature !== 6'h3F) begin bad++; $display("FAIL reset_sig got=%h exp=3f", if_a.signature); end
        total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if_a.busy); end
        total++; if (if_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", if_a.done); end
        total++; if (if_a.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", if_a.pass); end
        total++; if (if_a.pat_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", if_a.pat_cnt); end
        total++; if (st_c !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", st_c); end
    endtask

    task automatic test_single();
        if_a.start = 1'b1; if_a.golden = 6'h1F;
        if_a.com_valid = 1'b1; if_a.com_res = 6'h15;  // must be ignored on the start edge
        tick();
        if_a.start = 1'b0; if_a.com_res = 6'h22;
        total++; if (if_a.busy !== 1'b1) begin bad++; $display("FAIL single_busy_start got=%b exp=1", if_a.busy); end
        total++; if (if_a.signature !== 6'h3F) begin bad++; $display("FAIL single_seed got=%h exp=3f", if_a.signature); end
        tick();  // accept edge
        if_a.com_valid = 1'b0; if_a.com_res = 6'h00;
        total++; if (if_a.signature !== 6'h1F) begin bad++; $display("FAIL single_sig got=%h exp=1f", if_a.signature); end
        total++; if (if_a.done !== 1'b0) begin bad++; $display("FAIL single_done_early got=%b exp=0", if_a.done); end
        total++; if (if_a.pat_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", if_a.pat_cnt); end
        tick();
        total++; if (if_a.done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", if_a.done); end
        total++; if (if_a.pass !== 1'b1) begin bad++; $display("FAIL single_pass got=%b exp=1", if_a.pass); end
        total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", if_a.busy); end
        tick();
        total++; if (if_a.done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b exp=0", if_a.done); end
        total++; if (if_a.pass !== 1'b1) begin bad++; $display("FAIL single_pass_hold got=%b exp=1", if_a.pass); end
    endtask

    task automatic test_idle_valid();
        if_a.com_valid = 1'b1; if_a.com_res = 6'h15;
        repeat (3) tick();
        if_a.com_valid = 1'b0; if_a.com_res = 6'h00;
        total++; if (if_a.signature !== 6'h1F) begin bad++; $display("FAIL idle_valid_sig got=%h exp=1f", if_a.signature); end
        total++; if (if_a.pat_cnt !== 16'd1) begin bad++; $display("FAIL idle_valid_cnt got=%0d exp=1", if_a.pat_cnt); end
    endtask

    task automatic test_gap(input logic [5:0] gold, input logic exp_pass, input logic prev_pass);
        total++; if (if_b.pass !== prev_pass) begin bad++; $display("FAIL gap_pass_before got=%b exp=%b", if_b.pass, prev_pass); end
        if_b.start = 1'b1; if_b.golden = gold;
        tick();
        if_b.start = 1'b0;
        total++; if (if_b.pass !== 1'b0) begin bad++; $display("FAIL gap_pass_cleared got=%b exp=0", if_b.pass); end
        if_b.com_valid = 1'b1; if_b.com_res = 6'h22;
        tick();
        if_b.com_valid = 1'b0; if_b.com_res = 6'h3C;
        tick();
        tick();
        total++; if (if_b.signature !== 6'h1F) begin bad++; $display("FAIL gap_hold_sig got=%h exp=1f", if_b.signature); end
        total++; if (if_b.pat_cnt !== 16'd1) begin bad++; $display("FAIL gap_hold_cnt got=%0d exp=1", if_b.pat_cnt); end
        if_b.com_valid = 1'b1; if_b.com_res = 6'h13;
        tick();
        if_b.com_valid = 1'b0; if_b.com_res = 6'h00;
        total++; if (if_b.signature !== 6'h2D) begin bad++; $display("FAIL gap_sig got=%h exp=2d", if_b.signature); end
        total++; if (if_b.pat_cnt !== 16'd2) begin bad++; $display("FAIL gap_cnt got=%0d exp=2", if_b.pat_cnt); end
        total++; if (st_b !== ST_CHECK) begin bad++; $display("FAIL gap_state got=%0d exp=2", st_b); end
        tick();
        total++; if (if_b.done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b exp=1", if_b.done); end
        total++; if (if_b.pass !== exp_pass) begin bad++; $display("FAIL gap_pass got=%b exp=%b", if_b.pass, exp_pass); end
        tick();
    endtask

    task automatic test_stream();
        logic [5:0] exp_sig;
        int busy_cnt;
        int done_cnt;
        exp_sig = 6'h3F;
        for (int k = 0; k < 16; k++) exp_sig = model_next(exp_sig, 6'h00);
        if_c.start = 1'b1; if_c.golden = exp_sig;
        tick();
        if_c.start = 1'b0;
        busy_cnt = (if_c.busy === 1'b1) ? 1 : 0;
        done_cnt = 0;
        if_c.com_valid = 1'b1; if_c.com_res = 6'h00;
        for (int i = 1; i <= 22; i++) begin
            // A start with a different golden mid-session must be ignored.
            if (i == 6) begin
                if_c.start = 1'b1; if_c.golden = ~exp_sig;
            end else begin
                if_c.start = 1'b0;
            end
            tick();
            if (if_c.busy === 1'b1) busy_cnt++;
            if (if_c.done === 1'b1) done_cnt++;
            if (i == 1) begin
                total++; if (if_c.signature !== 6'h3D) begin bad++; $display("FAIL stream_first got=%h exp=3d", if_c.signature); end
            end
            if (i == 6) begin
                total++; if (if_c.pat_cnt !== 16'd6) begin bad++; $display("FAIL stream_start_ignored got=%0d exp=6", if_c.pat_cnt); end
            end
            if (i == 16) begin
                total++; if (if_c.signature !== exp_sig) begin bad++; $display("FAIL stream_sig got=%h exp=%h", if_c.signature, exp_sig); end
                total++; if (if_c.pat_cnt !== 16'd16) begin bad++; $display("FAIL stream_cnt got=%0d exp=16", if_c.pat_cnt); end
            end
        end
        if_c.com_valid = 1'b0;
        if_c.start = 1'b0;
        total++; if (busy_cnt !== 17) begin bad++; $display("FAIL stream_busy_len got=%0d exp=17", busy_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL stream_done_count got=%0d exp=1", done_cnt); end
        total++; if (if_c.pass !== 1'b1) begin bad++; $display("FAIL stream_pass got=%b exp=1", if_c.pass); end
        total++; if (if_c.signature !== exp_sig) begin bad++; $display("FAIL stream_idle_hold got=%h exp=%h", if_c.signature, exp_sig); end
    endtask

    task automatic test_abort();
        logic [5:0] exp_sig;
        int done_seen;
        bit finished;
        exp_sig = 6'h3F;
        for (int k = 0; k < 16; k++) exp_sig = model_next(exp_sig, 6'h00);
        if_c.start = 1'b1; if_c.golden = exp_sig;
        tick();
        if_c.start = 1'b0;
        if_c.com_valid = 1'b1; if_c.com_res = 6'h00;
        repeat (5) tick();
        total++; if (if_c.pat_cnt !== 16'd5) begin bad++; $display("FAIL abort_pre_cnt got=%0d exp=5", if_c.pat_cnt); end
        rst = 1'b1; if_c.com_valid = 1'b0;
        tick();
        rst = 1'b0;
        total++; if (if_c.signature !== 6'h3F) begin bad++; $display("FAIL abort_sig got=%h exp=3f", if_c.signature); end
        total++; if (if_c.pat_cnt !== 16'd0) begin bad++; $display("FAIL abort_cnt got=%0d exp=0", if_c.pat_cnt); end
        total++; if (if_c.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", if_c.busy); end
        total++; if (st_c !== ST_IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=0", st_c); end
        done_seen = 0;
        repeat (4) begin
            if (if_c.done === 1'b1) done_seen++;
            tick();
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
        // Fresh session after the abort runs to completion.
        if_c.start = 1'b1; if_c.golden = exp_sig;
        tick();
        if_c.start = 1'b0;
        if_c.com_valid = 1'b1; if_c.com_res = 6'h00;
        finished = 1'b0;
        for (int i = 0; i < 40 && !finished; i++) begin
            tick();
            if (if_c.done === 1'b1) finished = 1'b1;
        end
        if_c.com_valid = 1'b0;
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL rerun_timeout got=%b exp=1", finished); end
        total++; if (if_c.pass !== 1'b1) begin bad++; $display("FAIL rerun_pass got=%b exp=1", if_c.pass); end
        total++; if (if_c.signature !== exp_sig) begin bad++; $display("FAIL rerun_sig got=%h exp=%h", if_c.signature, exp_sig); end
        total++; if (if_c.pat_cnt !== 16'd16) begin bad++; $display("FAIL rerun_cnt got=%0d exp=16", if_c.pat_cnt); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        if_a.start = 1'b0; if_a.golden = '0; if_a.com_valid = 1'b0; if_a.com_res = '0;
        if_b.start = 1'b0; if_b.golden = '0; if_b.com_valid = 1'b0; if_b.com_res = '0;
        if_c.start = 1'b0; if_c.golden = '0; if_c.com_valid = 1'b0; if_c.com_res = '0;

        test_reset();
        test_single();
        test_idle_valid();
        test_gap(6'h2D, 1'b1, 1'b0);
        test_gap(6'h2C, 1'b0, 1'b1);
        test_stream();
        test_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
